// File: rtl/mult_sequencer_pkg.sv
// Shared definitions for the shift-add multiplier: opcodes served by HI/LO and FSM states.
// No logic; constants, types and one small decode helper.
// No backpressure of its own.
package mult_sequencer_pkg;

    localparam int unsigned MUL_WIDTH = 16;

    localparam logic [3:0] OP_GHI  = 4'd13;
    localparam logic [3:0] OP_GLO  = 4'd14;
    localparam logic [3:0] OP_MULT = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } mul_state_t;

    function automatic logic is_hilo_read(input logic [3:0] op);
        return (op == OP_GHI) || (op == OP_GLO);
    endfunction

endpackage

// File: rtl/mult_datapath.sv
// Operand registers, 2*WIDTH accumulator and WIDTH+1 bit adder for one shift-add step per cycle.
// product is the combinational next accumulator value; it is the final product on the last step.
// No backpressure: load and step are driven by the sequencer FSM.
module mult_datapath
    import mult_sequencer_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic [2*WIDTH-1:0] product
);

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH:0]     sum;

    // Carry-out of the add lands in the top bit after the right shift.
    always_comb begin
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, a_q} & {(WIDTH+1){b_q[0]}});
        product = (2*WIDTH)'({sum, acc_q[WIDTH-1:0]} >> 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (load) begin
            a_q   <= op_a;
            b_q   <= op_b;
            acc_q <= '0;
        end else if (step) begin
            acc_q <= product;
            b_q   <= b_q >> 1;
        end
    end

endmodule

// File: rtl/mult_sequencer.sv
// Multi-cycle unsigned multiplier controller owning HI/LO; serves ghi/glo reads and stalls the pipe.
// Latency: accept cycle to done pulse is WIDTH+1 cycles; HI/LO readable in the DONE cycle.
// Backpressure: stall is raised in RUN while a HI/LO read or a new mul is waiting.
module mult_sequencer
    import mult_sequencer_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mul,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             rd_hilo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mul_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic               load;
    logic               step;
    logic [2*WIDTH-1:0] product;

    assign load  = mul && ((state == S_IDLE) || (state == S_DONE));
    assign step  = (state == S_RUN);
    // A read in RUN would see stale HI/LO; a mul in RUN is held until DONE accepts it.
    assign stall = step && (rd_hilo || mul);

    mult_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .op_a    (op_a),
        .op_b    (op_b),
        .product (product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (mul) begin
                        state <= S_RUN;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (cnt == CNT_LAST) begin
                        state <= S_DONE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hi    <= product[2*WIDTH-1:WIDTH];
                        lo    <= product[WIDTH-1:0];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: directed table, back-to-back/read-stall/reset sequences, random ops vs a*b.
module tb_mult_sequencer;
    import mult_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mul;
    logic        rd_hilo;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        busy;
    logic        stall;
    logic        done;
    logic [15:0] hi;
    logic [15:0] lo;

    int n_checks = 0;
    int n_pass   = 0;

    mult_sequencer #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .mul     (mul),
        .op_a    (op_a),
        .op_b    (op_b),
        .rd_hilo (rd_hilo),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          rd_at;
        logic [15:0] exp_hi;
        logic [15:0] exp_lo;
        int          exp_stall;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Starts at posedge+1 of the accept cycle (mul already driven); returns at the negedge
    // of the DONE cycle, or with lat=0 if no done pulse appears within the budget.
    task automatic wait_done(input int rd_at, input int mul_at,
                             input logic [15:0] na, input logic [15:0] nb,
                             output int lat, output int bc, output int sc);
        lat = 0;
        bc  = 0;
        sc  = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            rd_hilo = (rd_at != 0 && k >= rd_at) ? is_hilo_read(OP_GHI) : 1'b0;
            mul     = (mul_at != 0 && k >= mul_at);
            if (mul) begin
                op_a = na;
                op_b = nb;
            end else begin
                op_a = 16'($urandom);
                op_b = 16'($urandom);
            end
            @(negedge clk);
            if (busy)  bc++;
            if (stall) sc++;
            if (done) begin
                lat = k;
                return;
            end
        end
    endtask

    task automatic after_done(input string name);
        @(posedge clk);
        #1;
        mul     = 1'b0;
        rd_hilo = 1'b0;
        @(negedge clk);
        check({name, "_done_1cyc"}, 32'(done), 32'd0);
        check({name, "_idle_busy"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc, sc, lat2, bc2, sc2, dcount, bcount, rd_at;
        logic [15:0] a, b;
        logic [31:0] exp_prod;

        vecs[0] = '{16'h0003, 16'h0005, 0,  16'h0000, 16'h000F, 0};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 4,  16'hFFFE, 16'h0001, 13};
        vecs[2] = '{16'h0000, 16'h1234, 0,  16'h0000, 16'h0000, 0};
        vecs[3] = '{16'h0001, 16'h0001, 16, 16'h0000, 16'h0001, 1};
        vecs[4] = '{16'hFFFF, 16'h0001, 1,  16'h0000, 16'hFFFF, 16};
        vecs[5] = '{16'h8000, 16'h0002, 0,  16'h0001, 16'h0000, 0};
        vecs[6] = '{16'h1234, 16'h5678, 10, 16'h0626, 16'h0060, 7};

        rst = 1'b1; mul = 1'b1; rd_hilo = 1'b1; op_a = 16'hBEEF; op_b = 16'h0001;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_hi", 32'(hi), 32'd0);
        check("rst_lo", 32'(lo), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        mul = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("idle_rd_stall", 32'(stall), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            mul = 1'b1; rd_hilo = 1'b0; op_a = vecs[i].a; op_b = vecs[i].b;
            wait_done(vecs[i].rd_at, 0, 16'h0, 16'h0, lat, bc, sc);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd17);
            check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'd16);
            check($sformatf("vec%0d_stall_cycles", i), 32'(sc), 32'(vecs[i].exp_stall));
            check($sformatf("vec%0d_done_stall", i), 32'(stall), 32'd0);
            check($sformatf("vec%0d_hi", i), 32'(hi), 32'(vecs[i].exp_hi));
            check($sformatf("vec%0d_lo", i), 32'(lo), 32'(vecs[i].exp_lo));
            after_done($sformatf("vec%0d", i));
        end

        // Back-to-back: second mul raised in RUN, read pending too; both resolve in DONE.
        mul = 1'b1; rd_hilo = 1'b0; op_a = 16'h0003; op_b = 16'h0005;
        wait_done(4, 5, 16'h00FF, 16'h0101, lat, bc, sc);
        check("b2b_first_latency", 32'(lat), 32'd17);
        check("b2b_first_stall_cycles", 32'(sc), 32'd13);
        check("b2b_done_stall", 32'(stall), 32'd0);
        check("b2b_read_new", {hi, lo}, 32'h0000_000F);
        wait_done(0, 0, 16'h0, 16'h0, lat2, bc2, sc2);
        check("b2b_second_latency", 32'(lat2), 32'd17);
        check("b2b_second_busy", 32'(bc2), 32'd16);
        check("b2b_second_prod", {hi, lo}, 32'h0000_FFFF);
        after_done("b2b");

        // Reset in the middle of a run.
        mul = 1'b1; op_a = 16'h8001; op_b = 16'h0002;
        wait_done(0, 0, 16'h0, 16'h0, lat, bc, sc);
        check("pre_rst_prod", {hi, lo}, 32'h0001_0002);
        after_done("pre_rst");
        mul = 1'b1; op_a = 16'h1234; op_b = 16'h5678;
        @(posedge clk);
        #1;
        mul = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("run_hold_hilo", {hi, lo}, 32'h0001_0002);
        check("run_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_hilo", {hi, lo}, 32'h0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        dcount = 0;
        bcount = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done) dcount++;
            if (busy) bcount++;
        end
        check("midrst_no_done", 32'(dcount), 32'd0);
        check("midrst_stays_idle", 32'(bcount), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 500; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            rd_at = $urandom_range(0, 16);
            exp_prod = {16'h0, a} * {16'h0, b};
            mul = 1'b1; rd_hilo = 1'b0; op_a = a; op_b = b;
            wait_done(rd_at, 0, 16'h0, 16'h0, lat, bc, sc);
            check($sformatf("rnd%0d_prod a=%0h b=%0h", i, a, b), {hi, lo}, exp_prod);
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'd17);
            check($sformatf("rnd%0d_stall_cycles", i), 32'(sc), 32'((rd_at == 0) ? 0 : 17 - rd_at));
            after_done($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
